// File: rtl/mips_defs.sv
// Shared opcode, FSM-state and forwarding-select definitions for the MEM stage.
// Latency/backpressure: n/a (constants and pure helper functions only).
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mstate_t;

    localparam logic [1:0] FWD_RT_RT_E = 2'd0;
    localparam logic [1:0] FWD_RT_WD_W = 2'd1;
    localparam logic [1:0] FWD_RT_C_M  = 2'd2;
    localparam logic       FWD_WD_RT_M = 1'b0;
    localparam logic       FWD_WD_WD_W = 1'b1;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/dm_bhw.sv
// Data memory with byte/half/word access, load extension and alignment flags.
// Latency: combinational read, write on the commit edge; no backpressure (commit is a one-cycle strobe).
module dm_bhw
    import mips_defs::*;
#(
    parameter int DM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_commit,
    input  logic [5:0]             i_op,
    input  logic [DM_ADDR_W+1:0]   i_addr,
    input  logic [31:0]            i_wdat,
    output logic [31:0]            o_rdat,
    output logic                   o_adel,
    output logic                   o_ades
);

    localparam int DEPTH = 1 << DM_ADDR_W;

    logic [31:0]          r_mem [DEPTH];
    logic [DM_ADDR_W-1:0] w_idx;
    logic [31:0]          w_word;
    logic [31:0]          w_wlane;
    logic [3:0]           w_be;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic                 w_word_op;
    logic                 w_half_op;
    logic                 w_misal;
    logic                 w_we;

    assign w_idx     = i_addr[DM_ADDR_W+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_word_op = (i_op == OP_LW) || (i_op == OP_SW);
    assign w_half_op = (i_op == OP_LH) || (i_op == OP_LHU) || (i_op == OP_SH);
    assign w_misal   = (w_word_op && (i_addr[1:0] != 2'b00)) || (w_half_op && i_addr[0]);
    assign o_adel    = is_load(i_op) && w_misal;
    assign o_ades    = is_store(i_op) && w_misal;
    assign w_we      = i_commit && is_store(i_op) && !w_misal;

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = i_wdat;
        case (i_op)
            OP_SW: w_be = 4'b1111;
            OP_SH: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{i_wdat[15:0]}};
            end
            OP_SB: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wlane = {4{i_wdat[7:0]}};
            end
            default: ;
        endcase
    end

    // Little-endian lane select; misaligned or non-load ops read as zero.
    always_comb begin
        w_byte = w_word[8*i_addr[1:0] +: 8];
        w_half = i_addr[1] ? w_word[31:16] : w_word[15:0];
        o_rdat = '0;
        if (!w_misal) begin
            case (i_op)
                OP_LW:  o_rdat = w_word;
                OP_LH:  o_rdat = {{16{w_half[15]}}, w_half};
                OP_LHU: o_rdat = {16'h0000, w_half};
                OP_LB:  o_rdat = {{24{w_byte[7]}}, w_byte};
                OP_LBU: o_rdat = {24'h000000, w_byte};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_stage_ext.sv
// MEM pipeline stage: E->M registers, RT forwarding, a3 decode, data memory and wait-state FSM.
// Latency: 1 + WAIT_CYCLES cycles per memory op; mem_busy stalls capture (en ignored) until the wait count drains.
module mem_stage_ext
    import mips_defs::*;
#(
    parameter int DM_ADDR_W   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] ir_e,
    input  logic [31:0] pc8_e,
    input  logic [31:0] c_e,
    input  logic [31:0] rt_e,
    input  logic [1:0]  fwd_rt_sel,
    input  logic        fwd_wd_sel,
    input  logic [31:0] wd_w,
    output logic [31:0] ir_m,
    output logic [31:0] pc8_m,
    output logic [31:0] c_m,
    output logic [4:0]  a3_m,
    output logic [31:0] dm_out,
    output logic        mem_busy,
    output logic        adel,
    output logic        ades
);

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    logic [31:0] r_ir_m;
    logic [31:0] r_pc8_m;
    logic [31:0] r_c_m;
    logic [31:0] r_rt_m;
    mstate_t     r_state;
    mstate_t     w_state_n;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_n;
    logic        w_busy;
    logic        w_cap;
    logic        w_commit;
    logic [31:0] w_rt_fwd;
    logic [31:0] w_mfwd;
    logic [5:0]  w_op_e;
    logic [5:0]  w_op_m;
    logic [4:0]  w_a3;

    assign w_op_e   = ir_e[31:26];
    assign w_op_m   = r_ir_m[31:26];
    assign w_busy   = (r_state == ST_ACCESS) && (r_cnt != 4'd0);
    assign w_cap    = en && !w_busy && !flush;
    // A flush on the commit edge aborts the access, so the write is gated too.
    assign w_commit = (r_state == ST_ACCESS) && (r_cnt == 4'd0) && !flush;

    always_comb begin
        w_rt_fwd = rt_e;
        case (fwd_rt_sel)
            FWD_RT_WD_W: w_rt_fwd = wd_w;
            FWD_RT_C_M:  w_rt_fwd = r_c_m;
            default:     ;
        endcase
    end

    assign w_mfwd = (fwd_wd_sel == FWD_WD_WD_W) ? wd_w : r_rt_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir_m  <= '0;
            r_pc8_m <= '0;
            r_c_m   <= '0;
            r_rt_m  <= '0;
        end else if (flush) begin
            r_ir_m  <= '0;
            r_pc8_m <= '0;
            r_c_m   <= '0;
            r_rt_m  <= '0;
        end else if (w_cap) begin
            r_ir_m  <= ir_e;
            r_pc8_m <= pc8_e;
            r_c_m   <= c_e;
            r_rt_m  <= w_rt_fwd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        if (flush) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
        end else begin
            if (r_state == ST_ACCESS) begin
                if (r_cnt != 4'd0) begin
                    w_cnt_n = r_cnt - 4'd1;
                end else begin
                    w_state_n = ST_DONE;
                end
            end
            if (w_cap) begin
                if (is_mem(w_op_e)) begin
                    w_state_n = ST_ACCESS;
                    w_cnt_n   = WAIT_N;
                end else begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end
            end
        end
    end

    always_comb begin
        w_a3 = 5'd0;
        if (w_op_m == OP_RTYPE) begin
            w_a3 = (r_ir_m[5:0] == FN_JR) ? 5'd0 : r_ir_m[15:11];
        end else if ((w_op_m[5:3] == 3'b001) || is_load(w_op_m)) begin
            w_a3 = r_ir_m[20:16];
        end else if (w_op_m == OP_JAL) begin
            w_a3 = 5'd31;
        end
    end

    dm_bhw #(
        .DM_ADDR_W (DM_ADDR_W)
    ) u_dm (
        .clk      (clk),
        .rst_n    (reset),
        .i_commit (w_commit),
        .i_op     (w_op_m),
        .i_addr   (r_c_m[DM_ADDR_W+1:0]),
        .i_wdat   (w_mfwd),
        .o_rdat   (dm_out),
        .o_adel   (adel),
        .o_ades   (ades)
    );

    assign ir_m     = r_ir_m;
    assign pc8_m    = r_pc8_m;
    assign c_m      = r_c_m;
    assign a3_m     = w_a3;
    assign mem_busy = w_busy;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed bench for mem_stage_ext: one instance with no wait states, one with three.
module tb_mem_stage_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic [31:0] ir_e;
    logic [31:0] pc8_e;
    logic [31:0] c_e;
    logic [31:0] rt_e;
    logic [1:0]  fwd_rt_sel;
    logic        fwd_wd_sel;
    logic [31:0] wd_w;

    logic [31:0] ir_m0, pc8_m0, c_m0, dm_out0;
    logic [4:0]  a3_m0;
    logic        busy0, adel0, ades0;
    logic [31:0] ir_m3, pc8_m3, c_m3, dm_out3;
    logic [4:0]  a3_m3;
    logic        busy3, adel3, ades3;

    int n_chk = 0;
    int n_err = 0;
    int wcnt3 = 0;
    int wbase;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    always #5 clk = ~clk;

    mem_stage_ext #(.DM_ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .ir_e(ir_e), .pc8_e(pc8_e),
        .c_e(c_e), .rt_e(rt_e), .fwd_rt_sel(fwd_rt_sel), .fwd_wd_sel(fwd_wd_sel), .wd_w(wd_w),
        .ir_m(ir_m0), .pc8_m(pc8_m0), .c_m(c_m0), .a3_m(a3_m0), .dm_out(dm_out0),
        .mem_busy(busy0), .adel(adel0), .ades(ades0)
    );

    mem_stage_ext #(.DM_ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .ir_e(ir_e), .pc8_e(pc8_e),
        .c_e(c_e), .rt_e(rt_e), .fwd_rt_sel(fwd_rt_sel), .fwd_wd_sel(fwd_wd_sel), .wd_w(wd_w),
        .ir_m(ir_m3), .pc8_m(pc8_m3), .c_m(c_m3), .a3_m(a3_m3), .dm_out(dm_out3),
        .mem_busy(busy3), .adel(adel3), .ades(ades3)
    );

    // Write strobe monitor for the wait-state instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (dut3.u_dm.w_we === 1'b1) wcnt3 = wcnt3 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd1, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    task automatic issue(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rt);
        ir_e  = ir;
        c_e   = addr;
        rt_e  = rt;
        pc8_e = pc8_e + 32'd4;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; flush = 1'b0;
        ir_e = '0; pc8_e = 32'h0040_0004; c_e = '0; rt_e = '0;
        fwd_rt_sel = 2'd0; fwd_wd_sel = 1'b0; wd_w = '0;
        step(2);
        check("rst_ir_m", ir_m0, 32'h0);
        check("rst_c_m", c_m0, 32'h0);
        check("rst_a3_m", {27'd0, a3_m0}, 32'h0);
        check("rst_dm_out", dm_out0, 32'h0);
        check("rst_flags", {29'd0, busy3, adel0, ades0}, 32'h0);
        @(negedge clk) reset = 1'b1;

        // Byte/half/word access with no wait states.
        issue(mk_i(SW, 5'd5), 32'h10, 32'h1122_3344); step(1);
        check("sw_ir_m", ir_m0, 32'hAC25_0000);
        check("sw_pc8_m", pc8_m0, 32'h0040_0008);
        check("sw_c_m", c_m0, 32'h10);
        check("sw_a3_m", {27'd0, a3_m0}, 32'h0);
        check("sw_busy", {31'd0, busy0}, 32'h0);
        issue(mk_i(LB, 5'd7), 32'h13, 32'h0); step(1);
        check("lb_13", dm_out0, 32'h0000_0011);
        check("lb_a3_m", {27'd0, a3_m0}, 32'd7);
        issue(mk_i(LH, 5'd7), 32'h12, 32'h0); step(1);
        check("lh_12", dm_out0, 32'h0000_1122);
        issue(mk_i(LBU, 5'd7), 32'h10, 32'h0); step(1);
        check("lbu_10", dm_out0, 32'h0000_0044);
        issue(mk_i(LW, 5'd7), 32'h10, 32'h0); step(1);
        check("lw_10", dm_out0, 32'h1122_3344);

        issue(mk_i(SB, 5'd5), 32'h21, 32'hFFFF_FF80); step(1);
        issue(mk_i(LB, 5'd8), 32'h21, 32'h0); step(1);
        check("lb_21", dm_out0, 32'hFFFF_FF80);
        issue(mk_i(LBU, 5'd8), 32'h21, 32'h0); step(1);
        check("lbu_21", dm_out0, 32'h0000_0080);
        issue(mk_i(LH, 5'd8), 32'h20, 32'h0); step(1);
        check("lh_20", dm_out0, 32'hFFFF_8000);
        issue(mk_i(LW, 5'd8), 32'h20, 32'h0); step(1);
        check("lw_20", dm_out0, 32'h0000_8000);

        // Alignment errors.
        issue(mk_i(SW, 5'd5), 32'h04, 32'hCAFE_BABE); step(1);
        issue(mk_i(LW, 5'd9), 32'h02, 32'h0); step(1);
        check("lw_02_adel", {31'd0, adel0}, 32'h1);
        check("lw_02_dm_out", dm_out0, 32'h0);
        issue(mk_i(SH, 5'd5), 32'h05, 32'h0000_1234); step(1);
        check("sh_05_ades", {30'd0, ades0, adel0}, 32'h2);
        issue(mk_i(LW, 5'd9), 32'h04, 32'h0); step(1);
        check("lw_04_unchanged", dm_out0, 32'hCAFE_BABE);
        check("lw_04_flags", {30'd0, ades0, adel0}, 32'h0);
        issue(mk_i(LHU, 5'd9), 32'h06, 32'h0); step(1);
        check("lhu_06", dm_out0, 32'h0000_CAFE);
        issue(mk_i(LH, 5'd9), 32'h06, 32'h0); step(1);
        check("lh_06", dm_out0, 32'hFFFF_CAFE);

        // Destination register decode.
        issue(mk_r(5'd9, 6'h21), 32'h0, 32'h0); step(1);
        check("a3_addu", {27'd0, a3_m0}, 32'd9);
        issue(mk_r(5'd9, 6'h08), 32'h0, 32'h0); step(1);
        check("a3_jr", {27'd0, a3_m0}, 32'd0);
        issue(32'h0C00_0010, 32'h0, 32'h0); step(1);
        check("a3_jal", {27'd0, a3_m0}, 32'd31);
        issue(32'h0800_0010, 32'h0, 32'h0); step(1);
        check("a3_j", {27'd0, a3_m0}, 32'd0);
        issue(mk_i(6'h0D, 5'd12), 32'h0, 32'h0); step(1);
        check("a3_ori", {27'd0, a3_m0}, 32'd12);

        // Forwarding.
        issue(mk_i(6'h09, 5'd3), 32'hA5A5_A5A5, 32'h0); step(1);
        check("addiu_c_m", c_m0, 32'hA5A5_A5A5);
        check("addiu_a3_m", {27'd0, a3_m0}, 32'd3);
        fwd_rt_sel = 2'd2;
        issue(mk_i(SW, 5'd3), 32'h40, 32'h0); step(1);
        fwd_rt_sel = 2'd0;
        issue(mk_i(LW, 5'd4), 32'h40, 32'h0); step(1);
        check("fwd_rt_c_m", dm_out0, 32'hA5A5_A5A5);
        issue(mk_i(SW, 5'd3), 32'h44, 32'h0BAD_0BAD); step(1);
        fwd_wd_sel = 1'b1; wd_w = 32'h5A5A_5A5A;
        issue(mk_i(LW, 5'd4), 32'h44, 32'h0); step(1);
        fwd_wd_sel = 1'b0;
        check("fwd_wd_w", dm_out0, 32'h5A5A_5A5A);
        fwd_rt_sel = 2'd1; wd_w = 32'h1357_9BDF;
        issue(mk_i(SW, 5'd3), 32'h48, 32'h0); step(1);
        fwd_rt_sel = 2'd0;
        issue(mk_i(LW, 5'd4), 32'h48, 32'h0); step(1);
        check("fwd_rt_wd_w", dm_out0, 32'h1357_9BDF);

        // Wait-state instance.
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        issue(mk_i(SW, 5'd5), 32'h10, 32'h1122_3344); step(1);
        check("w3_busy_0", {31'd0, busy3}, 32'h1);
        wbase = wcnt3;
        issue(mk_i(LW, 5'd6), 32'h10, 32'h0);
        for (int i = 1; i <= 2; i++) begin
            step(1);
            check("w3_busy_hold", {31'd0, busy3}, 32'h1);
            check("w3_frozen", ir_m3, 32'hAC25_0000);
        end
        step(1);
        check("w3_busy_drop", {31'd0, busy3}, 32'h0);
        check("w3_frozen_last", ir_m3, 32'hAC25_0000);
        check("w3_no_early_wr", wcnt3 - wbase, 32'd0);
        en = 1'b0;
        step(6);
        check("w3_one_write", wcnt3 - wbase, 32'd1);
        check("w3_done_busy", {31'd0, busy3}, 32'h0);
        en = 1'b1;
        step(1);
        check("w3_lw_captured", ir_m3, 32'h8C26_0000);
        check("w3_lw_busy", {31'd0, busy3}, 32'h1);
        step(3);
        check("w3_lw_data", dm_out3, 32'h1122_3344);

        // Flush during a wait.
        issue(mk_i(SW, 5'd5), 32'h20, 32'hDEAD_BEEF); step(2);
        check("fl_busy_cnt2", {31'd0, busy3}, 32'h1);
        wbase = wcnt3;
        flush = 1'b1; en = 1'b0; step(1); flush = 1'b0;
        check("fl_ir_m", ir_m3, 32'h0);
        check("fl_busy", {31'd0, busy3}, 32'h0);
        step(5);
        check("fl_no_write", wcnt3 - wbase, 32'd0);
        en = 1'b1;
        issue(mk_i(LW, 5'd6), 32'h20, 32'h0); step(4);
        check("fl_mem_intact", dm_out3, 32'h0);

        // Asynchronous reset mid-wait.
        issue(mk_i(SW, 5'd5), 32'h30, 32'h0000_0055); step(2);
        check("rs_busy_cnt2", {31'd0, busy3}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rs_ir_m", ir_m3, 32'h0);
        check("rs_c_m", c_m3, 32'h0);
        check("rs_pc8_m", pc8_m3, 32'h0);
        check("rs_busy", {31'd0, busy3}, 32'h0);
        check("rs_dm_out", dm_out3, 32'h0);
        @(negedge clk) reset = 1'b1;
        issue(mk_i(LW, 5'd6), 32'h10, 32'h0); step(4);
        check("rs_mem_cleared", dm_out3, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ext.md
Name: mem_stage_ext

Overview:
- Parametrised successor to the pipeline MEM stage.
- Holds the E→M pipeline registers, with stall (en) and flush (bubble) control.
- Applies pre- and post-register RT forwarding.
- Owns the data memory, with byte/halfword/word loads and stores, sign/zero extension and alignment-error flags.
- Supports an optional fixed memory wait-state count; a small FSM exports mem_busy to the hazard unit.

Parameters:
- DM_ADDR_W, 10, log2 of data-memory depth in 32-bit words (1024 words).
- WAIT_CYCLES, 0, extra cycles each load/store occupies M (0 = single-cycle, 0..15 legal).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  stage advance enable from hazard unit.
- flush  in  1  load bubble (all-zero) into M; priority over en.
- ir_e  in  32  instruction leaving E.
- pc8_e  in  32  PC+8 leaving E.
- c_e  in  32  ALU result (address for memory ops).
- rt_e  in  32  RT value read in E.
- fwd_rt_sel  in  2  pre-register RT source: 0 rt_e, 1 wd_w, 2 c_m, 3 rt_e.
- fwd_wd_sel  in  1  post-register store-data source: 0 rt_m, 1 wd_w.
- wd_w  in  32  W-stage writeback data.
- ir_m  out  32  registered instruction.
- pc8_m  out  32  registered PC+8.
- c_m  out  32  registered ALU result.
- a3_m  out  5  destination register of instruction in M.
- dm_out  out  32  extended load data.
- mem_busy  out  1  M holds a memory op that has not finished its wait states.
- adel  out  1  misaligned load in M.
- ades  out  1  misaligned store in M.

Behaviour:
- Reset (reset=0, async): ir_m, pc8_m, c_m, rt_m = 0; every memory word = 0; FSM=IDLE. Hence a3_m=0, dm_out=0, mem_busy=0, adel=ades=0.
- Effective capture: cap = en & ~mem_busy & ~flush.
- At posedge with flush=1: all M registers = 0, FSM=IDLE (an in-flight access is aborted with no write).
- At posedge with cap=1: M registers load E values; rt_m loads the fwd_rt_sel mux output.
- Otherwise all M registers hold. en=1 while mem_busy=1 is ignored.
- a3_m decode:
  - op 0x00: rd, or 0 when func=0x08 (jr).
  - op 0x08-0x0F and loads: rt.
  - op 0x03 (jal): 31.
  - all other ops: 0.
- Memory ops:
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
- Word index = c_m[DM_ADDR_W+1:2]; higher address bits are ignored (aliasing).
- Alignment: word ops need c_m[1:0]=0; half ops need c_m[0]=0; byte ops are always aligned.
- Misaligned load: adel=1, dm_out=0. Misaligned store: ades=1, no write. Both flags are combinational on M contents.
- Load result (combinational read): selects the byte/half addressed by c_m[1:0] (little-endian); lb/lh sign-extend, lbu/lhu zero-extend.
- Store data: mfwd (fwd_wd_sel mux) is replicated to every lane; byte enables are:
  - sw: 1111.
  - sh: c_m[1] ? 1100 : 0011.
  - sb: one-hot on c_m[1:0].
- FSM (registered cnt, 4 bits):
  - IDLE: no memory op in M. mem_busy=0.
  - ACCESS: entered on capture of a memory op, with cnt=WAIT_CYCLES.
    - mem_busy = (cnt≠0); cnt decrements each cycle while nonzero.
    - On the posedge where cnt=0: an aligned store commits, then the state moves to DONE (or to the next state if cap=1 on the same edge).
  - DONE: the access is complete, mem_busy=0 and no further writes occur. The state holds until the next capture or flush.
  - On capture of a non-memory op: IDLE.
- A store commits exactly once per occupancy. A stall (en=0) in DONE never rewrites memory.
- dm_out is valid only when mem_busy=0.
- A simultaneous commit and capture is legal: the write uses the pre-edge M values.

Decomposition:
- Shared package mips_defs:
  - opcode/func localparams (OP_LW…OP_SB, OP_JAL, FN_JR).
  - FSM state encodings (IDLE/ACCESS/DONE).
  - fwd select encodings.
- Natural sub-module: dm_bhw, holding the memory array, byte-enable write, and extend/alignment logic.
- mem_stage_ext holds the pipeline registers, forwarding muxes, a3 decode and FSM.

Test Plan:
- WAIT_CYCLES=0: sw $rt=0x11223344 at c_e=0x10 → mem[4]=0x11223344. Then lb at 0x13 → dm_out=0x00000011; lh at 0x12 → 0x00001122; lbu at 0x10 → 0x00000044.
- sb 0xFFFFFF80 at 0x21 → mem[8]=0x00008000. Then lb at 0x21 → 0xFFFFFF80; lbu → 0x00000080; lh at 0x20 → 0xFFFF8000.
- Misalignment: lw at 0x02 → adel=1, dm_out=0. sh at 0x05 → ades=1 and mem[1] is unchanged.
- WAIT_CYCLES=3: sw captured → mem_busy=1 for 3 cycles with en=1 held and registers frozen. The write occurs at the 4th edge; with en=0 for 5 further cycles there is exactly one write (monitor write strobe count=1).
- Forwarding: fwd_rt_sel=2 with c_m=0xA5A5A5A5 → rt_m=0xA5A5A5A5 after capture. Then fwd_wd_sel=1 with wd_w=0x5A5A5A5A → the stored word is 0x5A5A5A5A.
- Flush/reset: flush=1 during ACCESS with cnt=2 → ir_m=0, mem_busy=0, no write. reset=0 asserted mid-wait → all outputs 0 immediately (async) and memory cleared.
